// File: rtl/heartbeat_monitor.sv
// rtl/heartbeat_monitor.sv - heartbeat receiver: interval measurement, lock tracking and fault reporting
module heartbeat_monitor #(
    parameter int CLK_DIV    = 50000000,
    parameter int TOL        = 5000000,
    parameter int LOCK_EDGES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_in,
    input  logic             clr_err,
    output logic             alive,
    output logic             beat_edge,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             err_fast,
    output logic             err_slow,
    output logic [15:0]      err_count
);

    // Acceptance window for one interval, both ends inclusive.
    localparam logic [CNT_W-1:0] LO = CNT_W'(CLK_DIV - TOL);
    localparam logic [CNT_W-1:0] HI = CNT_W'(CLK_DIV + TOL);

    // The good-interval counter only has to reach LOCK_EDGES-1 before locking.
    localparam int               GOOD_W    = $clog2(LOCK_EDGES + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_EDGES - 1);

    localparam logic [1:0] ST_LOST    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic              s1;
    logic              s2;
    logic              s3;
    logic              toggle;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_max;
    logic [CNT_W-1:0]  interval;
    logic              at_timeout;
    logic              too_fast;
    logic              too_slow;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic              pv_nxt;
    logic              fast_nxt;
    logic              slow_nxt;
    logic              fault;

    // Two-flop synchronizer plus one delay flop for toggle detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= beat_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Either polarity of the heartbeat counts as a beat.
    assign toggle = s2 ^ s3;

    // The interval includes the edge cycle itself, so it is cnt+1; held at
    // all-ones once the counter has saturated.
    assign cnt_max    = &cnt;
    assign interval   = cnt_max ? cnt : cnt + CNT_W'(1);
    assign at_timeout = !toggle && (cnt == HI);
    assign too_fast   = interval < LO;
    assign too_slow   = interval > HI;

    // Free-running interval counter, restarted by every detected toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (toggle) begin
            cnt <= '0;
        end else if (!cnt_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Lock state machine; an edge always takes precedence over a timeout.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        pv_nxt    = 1'b0;
        fast_nxt  = 1'b0;
        slow_nxt  = 1'b0;
        fault     = 1'b0;
        case (state)
            ST_LOST: begin
                // No reference edge yet, so nothing can be measured here.
                if (toggle) begin
                    state_nxt = ST_ACQUIRE;
                    good_nxt  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (toggle) begin
                    pv_nxt = 1'b1;
                    if (too_fast) begin
                        fast_nxt = 1'b1;
                        good_nxt = '0;
                    end else if (too_slow) begin
                        slow_nxt = 1'b1;
                        good_nxt = '0;
                    end else if (good == GOOD_LAST) begin
                        state_nxt = ST_LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good + 1'b1;
                    end
                end else if (at_timeout) begin
                    // Losing a source that never locked is not a reportable fault.
                    state_nxt = ST_LOST;
                end
            end
            ST_LOCKED: begin
                if (toggle) begin
                    pv_nxt = 1'b1;
                    if (too_fast) begin
                        fast_nxt  = 1'b1;
                        fault     = 1'b1;
                        state_nxt = ST_ACQUIRE;
                        good_nxt  = '0;
                    end else if (too_slow) begin
                        slow_nxt  = 1'b1;
                        fault     = 1'b1;
                        state_nxt = ST_ACQUIRE;
                        good_nxt  = '0;
                    end
                end else if (at_timeout) begin
                    slow_nxt  = 1'b1;
                    fault     = 1'b1;
                    state_nxt = ST_LOST;
                end
            end
            default: begin
                state_nxt = ST_LOST;
                good_nxt  = '0;
            end
        endcase
    end

    // State and good-interval counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOST;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Registered status pulses; alive tracks the next state so it moves with the pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive        <= 1'b0;
            beat_edge    <= 1'b0;
            period_valid <= 1'b0;
            err_fast     <= 1'b0;
            err_slow     <= 1'b0;
        end else begin
            alive        <= (state_nxt == ST_LOCKED);
            beat_edge    <= toggle;
            period_valid <= pv_nxt;
            err_fast     <= fast_nxt;
            err_slow     <= slow_nxt;
        end
    end

    // Last measured interval, held between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_out <= '0;
        end else if (pv_nxt) begin
            period_out <= interval;
        end
    end

    // Saturating fault counter; a clear wins over a same-cycle fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 16'h0000;
        end else if (clr_err) begin
            err_count <= 16'h0000;
        end else if (fault && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end

endmodule

// File: doc/heartbeat_monitor.md
# heartbeat_monitor

Receive-side companion to the heartbeat generator. Watches a toggling heartbeat input from another FPGA or subsystem and measures the interval between toggles. It declares the source alive once the cadence is stable, and flags beats that are too fast or missing. Sits at the board/subsystem boundary and drives status LEDs and the fault register.

## Interface

- CLK_DIV, 50000000: nominal interval between heartbeat toggles, in clk cycles.
- TOL, 5000000: allowed deviation. In-range window is LO=CLK_DIV-TOL to HI=CLK_DIV+TOL, inclusive.
- LOCK_EDGES, 4: consecutive in-range intervals required to declare alive.
- CNT_W, 32: width of interval counter and period_out.

- clk  in  1  device clock
- rst  in  1  reset, asynchronous, active-high
- beat_in  in  1  heartbeat toggle, asynchronous to clk
- clr_err  in  1  synchronous clear of err_count
- alive  out  1  high while in LOCKED
- beat_edge  out  1  one-cycle pulse per detected toggle (either polarity)
- period_out  out  CNT_W  last measured interval, in cycles
- period_valid  out  1  one-cycle pulse when period_out updates
- err_fast  out  1  one-cycle pulse: interval < LO
- err_slow  out  1  one-cycle pulse: interval > HI, or timeout while LOCKED
- err_count  out  16  faults counted while LOCKED; saturates at 16'hFFFF

## Operation

- Input path: 2-flop synchronizer s1→s2, then s3 delay flop. edge = s2 ^ s3.
- Interval counter cnt:
  - On an edge cycle: cnt←0 and interval = cnt+1.
  - Otherwise cnt increments and saturates at all-ones.
  - Measured interval equals the cycle distance between consecutive edges.
- States:
  - LOST: reset state. Also holds a good-interval counter `good`.
  - ACQUIRE
  - LOCKED
- LOST:
  - No timeouts.
  - Edge → ACQUIRE, good←0. beat_edge pulses; no period_valid (no reference edge).
- ACQUIRE:
  - In-range edge: good+1. When good reaches LOCK_EDGES → LOCKED.
  - Edge with interval < LO: err_fast pulse, good←0, stay.
  - Edge with interval > HI (only possible in the timeout cycle): err_slow pulse, good←0, stay.
  - Timeout (cnt==HI with no edge): → LOST silently. No pulse, no count.
- LOCKED:
  - In-range edge: stay.
  - Edge < LO: err_fast, err_count+1, → ACQUIRE, good←0.
  - Timeout with no edge: err_slow, err_count+1, → LOST.
  - Edge in the timeout cycle: err_slow, err_count+1, → ACQUIRE, good←0. The edge wins over the timeout.
- Timeout fires once per gap, at the cycle where cnt==HI.
- period_out/period_valid update on every edge outside LOST, including out-of-range intervals.
- err_count:
  - Saturates at 16'hFFFF.
  - clr_err has priority: a simultaneous increment and clear gives 0.
- alive is registered: alive = (state==LOCKED).

## Timing

- Reset (async, any time including mid-lock): state LOST, cnt=0, good=0, sync flops 0, all outputs 0. err_count is cleared.
- Latency: beat_in changes before rising edge N, captured by s1 at N. All registered outputs and the state update at edge N+2, so they are visible in the cycle after N+2.
- beat_edge, period_valid, err_fast, err_slow are exactly one cycle wide.
- period_out holds its value between updates.
- alive falls in the same cycle err_fast/err_slow pulses from LOCKED.
- alive rises together with the period_valid of the LOCK_EDGES-th in-range interval.
- Input glitches shorter than one clk period may be missed. This is acceptable.

## Test plan

Bench parameters: CLK_DIV=10, TOL=2, LOCK_EDGES=3, so window 8..12.

- Reset/idle: assert rst mid-simulation with beat_in static → all outputs 0, state LOST. No err pulses over 100 cycles.
- Lock: toggle every 10 cycles →
  - 1st edge: beat_edge only.
  - Edges 2–4: period_valid with period_out=10.
  - alive rises with edge 4's outputs; err_count=0.
- Loss: from LOCKED, stop toggling → exactly one err_slow pulse and alive falls 13 cycles after the last beat_edge pulse. err_count=1; no further pulses over 100 cycles.
- Fast beat: from LOCKED, one interval of 6 → period_out=6, err_fast pulse, alive low, err_count+1. Three more 10-cycle intervals → alive high again.
- Window edges:
  - Intervals 8 and 12 → alive stays high, no errors.
  - Interval 7 → err_fast.
  - Gap of 13 → err_slow at the timeout cycle, and the 13th-cycle edge enters ACQUIRE.
- Counter/clear:
  - Force 65540 faults → err_count holds 16'hFFFF.
  - clr_err coincident with a fault → err_count=0.
  - rst asserted mid-LOCKED → alive, err_count, period_out go 0 immediately (asynchronously).
